acc_req_arbiter: RTL and testbench

- Shares one accelerator request/response port between NumReq independent requesters, e.g. several accelerator dispatchers or harts sharing one vector unit.
- Requests are granted round-robin and the grant is locked until the accelerator accepts the request.
- The source index of every accepted request goes into an in-order tracking FIFO, and each response is routed back to that source.
- The accelerator returns responses strictly in request-acceptance order.

---
 rtl/acc_req_arbiter.sv | 129 ++++++++++++
 tb/tb_acc_req_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator port between NumReq requesters.
// Grants lock until accepted; an in-order FIFO routes responses back to their source.
module acc_req_arbiter #(
   parameter int NumReq         = 2,
   parameter int ReqWidth       = 128,
   parameter int RespWidth      = 64,
   parameter int MaxOutstanding = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NumReq*ReqWidth-1:0]         req_data_i,
   input  logic [NumReq-1:0]                  req_valid_i,
   output logic [NumReq-1:0]                  req_ready_o,
   output logic [RespWidth-1:0]               resp_data_o,
   output logic [NumReq-1:0]                  resp_valid_o,
   input  logic [NumReq-1:0]                  resp_ready_i,
   output logic [ReqWidth-1:0]                acc_req_data_o,
   output logic                               acc_req_valid_o,
   input  logic                               acc_req_ready_i,
   input  logic [RespWidth-1:0]               acc_resp_data_i,
   input  logic                               acc_resp_valid_i,
   output logic                               acc_resp_ready_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                               orphan_resp_o
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding+1);
   localparam logic [IdxW-1:0] LastReq  = IdxW'(NumReq-1);
   localparam logic [PtrW-1:0] LastSlot = PtrW'(MaxOutstanding-1);
   localparam logic [CntW-1:0] Depth    = CntW'(MaxOutstanding);

   logic [IdxW-1:0] rr_ptr_q;
   logic            lock_q;
   logic [IdxW-1:0] lock_idx_q;
   logic [IdxW-1:0] cand;
   logic [IdxW-1:0] scan;
   logic            found;
   logic [IdxW-1:0] gnt;
   logic            accept;

   logic [IdxW-1:0] fifo_mem_q [MaxOutstanding];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] cnt_q;
   logic            fifo_empty;
   logic            fifo_full;
   logic [IdxW-1:0] head;
   logic            pop;

   // First valid requester at or after the pointer, wrapping modulo NumReq
   always_comb begin
      cand  = rr_ptr_q;
      found = 1'b0;
      scan  = rr_ptr_q;
      for (int k = 0; k < NumReq; k++) begin
         if (!found && req_valid_i[scan]) begin
            cand  = scan;
            found = 1'b1;
         end
         scan = (scan == LastReq) ? '0 : scan + 1'b1;
      end
   end

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == Depth);
   assign gnt        = lock_q ? lock_idx_q : cand;

   assign acc_req_valid_o = ((|req_valid_i) | lock_q) & ~fifo_full;
   assign acc_req_data_o  = req_data_i[int'(gnt)*ReqWidth +: ReqWidth];
   assign accept          = acc_req_valid_o & acc_req_ready_i;

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[gnt] = 1'b1;
   end

   assign head        = fifo_mem_q[rd_ptr_q];
   assign resp_data_o = acc_resp_data_i;

   // Empty FIFO: sink the stray response so the accelerator never stalls on it
   always_comb begin
      resp_valid_o     = '0;
      acc_resp_ready_o = acc_resp_valid_i;
      if (!fifo_empty) begin
         resp_valid_o[head] = acc_resp_valid_i;
         acc_resp_ready_o   = resp_ready_i[head];
      end
   end

   assign pop = acc_resp_valid_i & acc_resp_ready_o & ~fifo_empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (accept) begin
         rr_ptr_q <= (gnt == LastReq) ? '0 : gnt + 1'b1;
         lock_q   <= 1'b0;
      end else if (acc_req_valid_o) begin
         lock_q     <= 1'b1;
         lock_idx_q <= gnt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) fifo_mem_q[wr_ptr_q] <= gnt;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         orphan_resp_o <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
         if (accept && !pop) cnt_q <= cnt_q + 1'b1;
         else if (pop && !accept) cnt_q <= cnt_q - 1'b1;
         orphan_resp_o <= acc_resp_valid_i & fifo_empty;
      end
   end

   assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter: two instances (depth 4 and depth 2)
// driven by identical inputs; each scenario checks the instance it targets.
module tb_acc_req_arbiter;

   logic        clk;
   logic        rst;
   logic [47:0] req_data;
   logic [2:0]  req_valid;
   logic [2:0]  resp_ready;
   logic        acc_req_ready;
   logic [15:0] acc_resp_data;
   logic        acc_resp_valid;

   logic [2:0]  req_ready_a, resp_valid_a;
   logic [15:0] resp_data_a, acc_req_data_a;
   logic        acc_req_valid_a, acc_resp_ready_a, orphan_a;
   logic [2:0]  out_a;

   logic [2:0]  req_ready_b, resp_valid_b;
   logic [15:0] resp_data_b, acc_req_data_b;
   logic        acc_req_valid_b, acc_resp_ready_b, orphan_b;
   logic [1:0]  out_b;

   int n_checks;
   int n_fail;

   logic       stall_pend;
   logic [1:0] stall_idx;

   acc_req_arbiter #(
      .NumReq(3), .ReqWidth(16), .RespWidth(16), .MaxOutstanding(4)
   ) u_a (
      .clk_i(clk), .rst_i(rst),
      .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready_a),
      .resp_data_o(resp_data_a), .resp_valid_o(resp_valid_a),
      .resp_ready_i(resp_ready),
      .acc_req_data_o(acc_req_data_a), .acc_req_valid_o(acc_req_valid_a),
      .acc_req_ready_i(acc_req_ready),
      .acc_resp_data_i(acc_resp_data), .acc_resp_valid_i(acc_resp_valid),
      .acc_resp_ready_o(acc_resp_ready_a),
      .outstanding_o(out_a), .orphan_resp_o(orphan_a)
   );

   acc_req_arbiter #(
      .NumReq(3), .ReqWidth(16), .RespWidth(16), .MaxOutstanding(2)
   ) u_b (
      .clk_i(clk), .rst_i(rst),
      .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready_b),
      .resp_data_o(resp_data_b), .resp_valid_o(resp_valid_b),
      .resp_ready_i(resp_ready),
      .acc_req_data_o(acc_req_data_b), .acc_req_valid_o(acc_req_valid_b),
      .acc_req_ready_i(acc_req_ready),
      .acc_resp_data_i(acc_resp_data), .acc_resp_valid_i(acc_resp_valid),
      .acc_resp_ready_o(acc_resp_ready_b),
      .outstanding_o(out_b), .orphan_resp_o(orphan_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A stalled requester must still be valid on the following cycle
   always @(posedge clk) begin
      if (rst) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            n_checks++;
            if (req_valid[stall_idx] !== 1'b1) begin
               n_fail++;
               $display("FAIL lock_stable: req %0d valid=%b required 1",
                        stall_idx, req_valid[stall_idx]);
            end
         end
         stall_pend = acc_req_valid_a && !acc_req_ready;
         stall_idx  = acc_req_data_a[1:0];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid      = '0;
      resp_ready     = '0;
      acc_req_ready  = 1'b0;
      acc_resp_data  = '0;
      acc_resp_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      #1;
      n_checks += 6;
      if (acc_req_valid_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_acc_req_valid: got %b want 0", acc_req_valid_a);
      end
      if (req_ready_a !== 3'b000) begin
         n_fail++; $display("FAIL rst_req_ready: got %b want 000", req_ready_a);
      end
      if (resp_valid_a !== 3'b000) begin
         n_fail++; $display("FAIL rst_resp_valid: got %b want 000", resp_valid_a);
      end
      if (acc_resp_ready_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_acc_resp_ready: got %b want 0", acc_resp_ready_a);
      end
      if (out_a !== 3'd0) begin
         n_fail++; $display("FAIL rst_outstanding: got %0d want 0", out_a);
      end
      if (orphan_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_orphan: got %b want 0", orphan_a);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [6];
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      do_reset();
      acc_req_ready = 1'b1;
      resp_ready    = 3'b111;
      for (int c = 0; c < 7; c++) begin
         req_valid      = (c < 6) ? 3'b111 : 3'b000;
         acc_resp_valid = (c > 0);
         acc_resp_data  = 16'h5000 + 16'(c);
         #1;
         if (c < 6) begin
            n_checks += 2;
            if (acc_req_data_a !== 16'hA000 + 16'(exp_g[c])) begin
               n_fail++;
               $display("FAIL rr_grant c%0d: got %h want %h", c,
                        acc_req_data_a, 16'hA000 + 16'(exp_g[c]));
            end
            if (req_ready_a !== 3'(1 << exp_g[c])) begin
               n_fail++;
               $display("FAIL rr_ready c%0d: got %b want %b", c,
                        req_ready_a, 3'(1 << exp_g[c]));
            end
         end
         if (c > 0) begin
            n_checks += 2;
            if (resp_valid_a !== 3'(1 << exp_g[c-1])) begin
               n_fail++;
               $display("FAIL rr_resp_route c%0d: got %b want %b", c,
                        resp_valid_a, 3'(1 << exp_g[c-1]));
            end
            if (resp_data_a !== 16'h5000 + 16'(c)) begin
               n_fail++;
               $display("FAIL rr_resp_data c%0d: got %h want %h", c,
                        resp_data_a, 16'h5000 + 16'(c));
            end
         end
         tick();
      end
      clear_inputs();
      n_checks++;
      if (out_a !== 3'd0) begin
         n_fail++; $display("FAIL rr_drained: got %0d want 0", out_a);
      end
   endtask

   task automatic test_lock();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req_valid     = (c == 0) ? 3'b010 : 3'b011;
         acc_req_ready = 1'b0;
         #1;
         n_checks += 2;
         if (acc_req_data_a !== 16'hA001) begin
            n_fail++; $display("FAIL lock_hold c%0d: got %h want a001", c, acc_req_data_a);
         end
         if (req_ready_a !== 3'b000) begin
            n_fail++; $display("FAIL lock_ready c%0d: got %b want 000", c, req_ready_a);
         end
         tick();
      end
      acc_req_ready = 1'b1;
      #1;
      n_checks += 2;
      if (acc_req_data_a !== 16'hA001) begin
         n_fail++; $display("FAIL lock_accept_data: got %h want a001", acc_req_data_a);
      end
      if (req_ready_a !== 3'b010) begin
         n_fail++; $display("FAIL lock_accept_ready: got %b want 010", req_ready_a);
      end
      tick();
      req_valid = 3'b001;
      #1;
      n_checks++;
      if (acc_req_data_a !== 16'hA000 || req_ready_a !== 3'b001) begin
         n_fail++;
         $display("FAIL lock_next: got %h/%b want a000/001", acc_req_data_a, req_ready_a);
      end
      tick();
      clear_inputs();
      n_checks++;
      if (out_a !== 3'd2) begin
         n_fail++; $display("FAIL lock_outstanding: got %0d want 2", out_a);
      end
   endtask

   task automatic test_full();
      do_reset();
      acc_req_ready = 1'b1;
      resp_ready    = 3'b111;
      req_valid     = 3'b001;
      tick();
      req_valid = 3'b010;
      tick();
      req_valid = 3'b100;
      #1;
      n_checks += 3;
      if (out_b !== 2'd2) begin
         n_fail++; $display("FAIL full_count: got %0d want 2", out_b);
      end
      if (acc_req_valid_b !== 1'b0 || req_ready_b !== 3'b000) begin
         n_fail++;
         $display("FAIL full_block: got %b/%b want 0/000", acc_req_valid_b, req_ready_b);
      end
      acc_resp_valid = 1'b1;
      acc_resp_data  = 16'h0BEE;
      #1;
      if (resp_valid_b !== 3'b001 || acc_resp_ready_b !== 1'b1
          || acc_req_valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pop: got rv=%b rdy=%b qv=%b want 001/1/0",
                  resp_valid_b, acc_resp_ready_b, acc_req_valid_b);
      end
      tick();
      acc_resp_valid = 1'b0;
      #1;
      n_checks += 3;
      if (out_b !== 2'd1) begin
         n_fail++; $display("FAIL full_after_pop: got %0d want 1", out_b);
      end
      if (acc_req_valid_b !== 1'b1 || acc_req_data_b !== 16'hA002) begin
         n_fail++;
         $display("FAIL full_resume: got %b/%h want 1/a002", acc_req_valid_b, acc_req_data_b);
      end
      tick();
      clear_inputs();
      if (out_b !== 2'd2) begin
         n_fail++; $display("FAIL full_refill: got %0d want 2", out_b);
      end
   endtask

   task automatic test_resp_stall();
      do_reset();
      acc_req_ready = 1'b1;
      req_valid     = 3'b100;
      tick();
      req_valid = 3'b001;
      tick();
      req_valid      = 3'b000;
      acc_resp_valid = 1'b1;
      acc_resp_data  = 16'h1234;
      for (int c = 0; c < 3; c++) begin
         resp_ready = (c < 2) ? 3'b011 : 3'b111;
         #1;
         n_checks += 3;
         if (resp_valid_a !== 3'b100) begin
            n_fail++; $display("FAIL stall_route c%0d: got %b want 100", c, resp_valid_a);
         end
         if (acc_resp_ready_a !== (c == 2)) begin
            n_fail++;
            $display("FAIL stall_ready c%0d: got %b want %b", c, acc_resp_ready_a, c == 2);
         end
         if (resp_data_a !== 16'h1234) begin
            n_fail++; $display("FAIL stall_data c%0d: got %h want 1234", c, resp_data_a);
         end
         tick();
      end
      #1;
      n_checks++;
      if (resp_valid_a !== 3'b001 || acc_resp_ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_head_adv: got %b/%b want 001/1", resp_valid_a, acc_resp_ready_a);
      end
      tick();
      clear_inputs();
      n_checks++;
      if (out_a !== 3'd0) begin
         n_fail++; $display("FAIL stall_drained: got %0d want 0", out_a);
      end
   endtask

   task automatic test_orphan();
      do_reset();
      acc_resp_valid = 1'b1;
      acc_resp_data  = 16'hDEAD;
      #1;
      n_checks += 3;
      if (acc_resp_ready_a !== 1'b1 || resp_valid_a !== 3'b000) begin
         n_fail++;
         $display("FAIL orphan_sink: got %b/%b want 1/000", acc_resp_ready_a, resp_valid_a);
      end
      if (orphan_a !== 1'b0) begin
         n_fail++; $display("FAIL orphan_early: got %b want 0", orphan_a);
      end
      tick();
      acc_resp_valid = 1'b0;
      if (orphan_a !== 1'b1) begin
         n_fail++; $display("FAIL orphan_pulse: got %b want 1", orphan_a);
      end
      tick();
      n_checks++;
      if (orphan_a !== 1'b0) begin
         n_fail++; $display("FAIL orphan_clear: got %b want 0", orphan_a);
      end
   endtask

   task automatic test_reset_mid_lock();
      logic [2:0] seq [3];
      seq = '{3'b100, 3'b001, 3'b010};
      do_reset();
      acc_req_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         req_valid = seq[c];
         tick();
      end
      acc_req_ready = 1'b0;
      req_valid     = 3'b100;
      tick();
      req_valid = 3'b101;
      #1;
      n_checks += 2;
      if (out_a !== 3'd3) begin
         n_fail++; $display("FAIL rml_count: got %0d want 3", out_a);
      end
      if (acc_req_data_a !== 16'hA002 || acc_req_valid_a !== 1'b1) begin
         n_fail++;
         $display("FAIL rml_locked: got %h/%b want a002/1", acc_req_data_a, acc_req_valid_a);
      end
      #2;
      rst       = 1'b1;
      req_valid = 3'b000;
      #1;
      n_checks += 2;
      if (out_a !== 3'd0) begin
         n_fail++; $display("FAIL rml_async_count: got %0d want 0", out_a);
      end
      if (acc_req_valid_a !== 1'b0 || req_ready_a !== 3'b000) begin
         n_fail++;
         $display("FAIL rml_async_req: got %b/%b want 0/000", acc_req_valid_a, req_ready_a);
      end
      tick();
      rst           = 1'b0;
      req_valid     = 3'b101;
      acc_req_ready = 1'b1;
      #1;
      n_checks++;
      if (acc_req_data_a !== 16'hA000 || req_ready_a !== 3'b001) begin
         n_fail++;
         $display("FAIL rml_priority: got %h/%b want a000/001", acc_req_data_a, req_ready_a);
      end
      tick();
      clear_inputs();
      n_checks++;
      if (out_a !== 3'd1) begin
         n_fail++; $display("FAIL rml_push: got %0d want 1", out_a);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      stall_pend = 1'b0;
      stall_idx  = '0;
      req_data   = {16'hA002, 16'hA001, 16'hA000};
      test_reset();
      test_round_robin();
      test_lock();
      test_full();
      test_resp_stall();
      test_orphan();
      test_reset_mid_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
